// File: rtl/bnn_output_classifier.sv
// rtl/bnn_output_classifier.sv - serial XNOR-popcount output layer with argmax and handshakes
module bnn_output_classifier #(
   parameter int NUM_IN      = 4,
   parameter int NUM_CLASSES = 4,
   parameter int CLS_W       = 2,
   parameter int SCORE_W     = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NUM_IN-1:0]  in_act,
   input  logic               wl_en,
   input  logic [NUM_IN-1:0]  wl_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CLS_W-1:0]   out_class,
   output logic [SCORE_W-1:0] out_score
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COMPUTE = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;
   localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASSES - 1);

   logic [1:0]         state_q, state_d;
   logic [NUM_IN-1:0]  act_q, act_d;
   logic [NUM_IN-1:0]  rows_q [NUM_CLASSES];
   logic [NUM_IN-1:0]  rows_d [NUM_CLASSES];
   logic [CLS_W-1:0]   wl_ptr_q, wl_ptr_d;
   logic [CLS_W-1:0]   idx_q, idx_d;
   logic [SCORE_W-1:0] best_score_q, best_score_d;
   logic [CLS_W-1:0]   best_class_q, best_class_d;
   logic [CLS_W-1:0]   out_class_q, out_class_d;
   logic [SCORE_W-1:0] out_score_q, out_score_d;

   logic [NUM_IN-1:0]  match;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] cand_score;
   logic [CLS_W-1:0]   cand_class;

   always_comb begin
      match = ~(act_q ^ rows_q[idx_q]);
      score = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         score = score + SCORE_W'(match[i]);
      end
      // First class seeds the running best; later classes win only on a strict improvement.
      if (idx_q == '0 || score > best_score_q) begin
         cand_score = score;
         cand_class = idx_q;
      end else begin
         cand_score = best_score_q;
         cand_class = best_class_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      act_d        = act_q;
      rows_d       = rows_q;
      wl_ptr_d     = wl_ptr_q;
      idx_d        = idx_q;
      best_score_d = best_score_q;
      best_class_d = best_class_q;
      out_class_d  = out_class_q;
      out_score_d  = out_score_q;
      case (state_q)
         S_IDLE: begin
            if (wl_en) begin
               rows_d[wl_ptr_q] = wl_data;
               wl_ptr_d = (wl_ptr_q == LAST_IDX) ? '0 : wl_ptr_q + CLS_W'(1);
            end
            if (in_valid) begin
               act_d        = in_act;
               idx_d        = '0;
               best_score_d = '0;
               best_class_d = '0;
               state_d      = S_COMPUTE;
            end
         end
         S_COMPUTE: begin
            best_score_d = cand_score;
            best_class_d = cand_class;
            if (idx_q == LAST_IDX) begin
               out_class_d = cand_class;
               out_score_d = cand_score;
               state_d     = S_DONE;
            end else begin
               idx_d = idx_q + CLS_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         act_q        <= '0;
         for (int c = 0; c < NUM_CLASSES; c++) begin
            rows_q[c] <= '0;
         end
         wl_ptr_q     <= '0;
         idx_q        <= '0;
         best_score_q <= '0;
         best_class_q <= '0;
         out_class_q  <= '0;
         out_score_q  <= '0;
      end else begin
         state_q      <= state_d;
         act_q        <= act_d;
         rows_q       <= rows_d;
         wl_ptr_q     <= wl_ptr_d;
         idx_q        <= idx_d;
         best_score_q <= best_score_d;
         best_class_q <= best_class_d;
         out_class_q  <= out_class_d;
         out_score_q  <= out_score_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_class = out_class_q;
   assign out_score = out_score_q;

endmodule

// File: tb/tb_bnn_output_classifier.sv
// tb/tb_bnn_output_classifier.sv - directed table-driven bench for bnn_output_classifier
module tb_bnn_output_classifier;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_act;
   logic       wl_en;
   logic [3:0] wl_data;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_class;
   logic [2:0] out_score;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] act;
      logic [1:0] cls;
      logic [2:0] score;
   } vec_t;

   vec_t vecs [7];

   bnn_output_classifier #(
      .NUM_IN(4), .NUM_CLASSES(4), .CLS_W(2), .SCORE_W(3)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
      .wl_en(wl_en), .wl_data(wl_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_class(out_class), .out_score(out_score)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers one sample, scrambles in_act after acceptance, waits (bounded) for out_valid.
   task automatic run_sample(input logic [3:0] act, output int cls, output int score, output int lat);
      chk("in_ready_before_accept", int'(in_ready), 1);
      in_valid = 1'b1;
      in_act   = act;
      step();
      in_valid = 1'b0;
      in_act   = ~act;
      lat = 0;
      do begin
         step();
         lat++;
      end while (!out_valid && lat < 20);
      cls   = int'(out_class);
      score = int'(out_score);
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("out_valid_after_accept", int'(out_valid), 0);
      chk("in_ready_after_accept", int'(in_ready), 1);
   endtask

   task automatic load_row(input logic [3:0] row);
      wl_en   = 1'b1;
      wl_data = row;
      step();
      wl_en   = 1'b0;
   endtask

   initial begin
      int cls, score, lat;
      int seen;

      vecs[0] = '{4'b0011, 2'd0, 3'd4};
      vecs[1] = '{4'b1111, 2'd2, 3'd4};
      vecs[2] = '{4'b0101, 2'd0, 3'd2};
      vecs[3] = '{4'b0000, 2'd3, 3'd4};
      vecs[4] = '{4'b1100, 2'd1, 3'd4};
      vecs[5] = '{4'b0001, 2'd0, 3'd3};
      vecs[6] = '{4'b1000, 2'd1, 3'd3};

      rst_n = 1'b0; in_valid = 1'b0; in_act = '0;
      wl_en = 1'b0; wl_data = '0; out_ready = 1'b0;
      #1;
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_class", int'(out_class), 0);
      chk("reset_out_score", int'(out_score), 0);
      step();
      step();
      rst_n = 1'b1;

      // Unloaded weights are all zero: every class scores 4 against 0000.
      run_sample(4'b0000, cls, score, lat);
      chk("t1_latency", lat, 4);
      chk("t1_class", cls, 0);
      chk("t1_score", score, 4);
      release_out();

      load_row(4'b0011);
      load_row(4'b1100);
      load_row(4'b1111);
      load_row(4'b0000);

      for (int v = 0; v < 7; v++) begin
         run_sample(vecs[v].act, cls, score, lat);
         chk($sformatf("vec%0d_latency", v), lat, 4);
         chk($sformatf("vec%0d_class", v), cls, int'(vecs[v].cls));
         chk($sformatf("vec%0d_score", v), score, int'(vecs[v].score));
         release_out();
      end

      // Backpressure in DONE with stray in_valid pulses.
      run_sample(4'b1111, cls, score, lat);
      chk("bp_class", cls, 2);
      for (int c = 0; c < 10; c++) begin
         in_valid = c[0];
         in_act   = 4'b0011;
         step();
         chk("bp_out_valid", int'(out_valid), 1);
         chk("bp_in_ready", int'(in_ready), 0);
         chk("bp_out_class", int'(out_class), 2);
         chk("bp_out_score", int'(out_score), 4);
      end
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("bp_release_out_valid", int'(out_valid), 0);
      chk("bp_release_no_accept", int'(in_ready), 1);
      chk("hold_class_after_drop", int'(out_class), 2);
      chk("hold_score_after_drop", int'(out_score), 4);

      // wl_en during COMPUTE must not touch rows or wl_ptr.
      in_valid = 1'b1;
      in_act   = 4'b0011;
      step();
      in_valid = 1'b0;
      wl_en    = 1'b1;
      wl_data  = 4'b1010;
      lat = 0;
      do begin
         step();
         lat++;
      end while (!out_valid && lat < 20);
      wl_en = 1'b0;
      chk("wl_compute_latency", lat, 4);
      chk("wl_compute_class", int'(out_class), 0);
      chk("wl_compute_score", int'(out_score), 4);
      release_out();

      // wl_ptr still 0: overwrite row0 with 0000 -> scores 2,0,2,2.
      load_row(4'b0000);
      run_sample(4'b0011, cls, score, lat);
      chk("ptr_kept_class", cls, 0);
      chk("ptr_kept_score", score, 2);
      release_out();

      // Simultaneous write (row1=0011) and accept: new row must be used.
      wl_en    = 1'b1;
      wl_data  = 4'b0011;
      run_sample(4'b0011, cls, score, lat);
      wl_en    = 1'b0;
      chk("simul_wl_class", cls, 1);
      chk("simul_wl_score", score, 4);
      release_out();

      // Async reset mid-COMPUTE aborts and clears weights.
      in_valid = 1'b1;
      in_act   = 4'b0011;
      step();
      in_valid = 1'b0;
      step();
      step();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", int'(in_ready), 1);
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_out_class", int'(out_class), 0);
      chk("abort_out_score", int'(out_score), 0);
      step();
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (out_valid) seen = 1;
      end
      chk("abort_no_out_valid", seen, 0);
      run_sample(4'b0000, cls, score, lat);
      chk("post_abort_latency", lat, 4);
      chk("post_abort_class", cls, 0);
      chk("post_abort_score", score, 4);
      release_out();
      run_sample(4'b0011, cls, score, lat);
      chk("rows_cleared_class", cls, 0);
      chk("rows_cleared_score", score, 2);
      release_out();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
